// File: rtl/protocheck_axil_pkg.sv
// Shared definitions for the AXI4-Lite register bank with live protocol checking:
// response codes, STATUS bit positions and the STATUS register layout.
package protocheck_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_W    = 4;
  localparam int STS_AW_DROP = 0;
  localparam int STS_W_DROP  = 1;
  localparam int STS_AR_DROP = 2;
  localparam int STS_PAYLOAD = 3;

  // First member is the MSB, so aw_drop lands on bit 0.
  typedef struct packed {
    logic payload_chg;
    logic ar_drop;
    logic w_drop;
    logic aw_drop;
  } status_t;

endpackage

// File: rtl/protocheck_axil_slave_if.sv
// AXI4-Lite bus bundle between the master/interconnect and the register bank.
interface protocheck_axil_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/protocheck_valid_monitor.sv
// Watches one VALID/READY channel: flags VALID dropping before its handshake and
// payload changing while VALID is held without READY.
module protocheck_valid_monitor #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 drop_o,
  output logic                 change_o
);
  logic                 valid_q;
  logic                 ready_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 pending;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_i;
      ready_q   <= ready_i;
      payload_q <= payload_i;
    end
  end

  // Offered at the last edge but not taken: the master still owes a stable transfer.
  assign pending  = valid_q & ~ready_q;
  assign drop_o   = pending & ~valid_i;
  assign change_o = pending & valid_i & (payload_i != payload_q);

endmodule

// File: rtl/protocheck_axil_slave.sv
// AXI4-Lite slave: NUM_REGS R/W registers, a sticky W1C STATUS register fed by
// per-channel protocol monitors, and a registered protocol_err summary flag.
module protocheck_axil_slave
  import protocheck_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  protocheck_axil_slave_if.slave  s00_axi,
  output logic [NUM_REGS*32-1:0]  reg_out,
  output logic                    protocol_err
);
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("protocheck_axil_slave: only 32-bit data is supported");
  end
  if ((NUM_REGS + 1) * 4 > (1 << C_S_AXI_ADDR_WIDTH)) begin : g_bad_addr_width
    $error("protocheck_axil_slave: address width cannot cover NUM_REGS plus STATUS");
  end

  logic              aw_held_q, aw_held_d;
  logic [IDX_W-1:0]  aw_idx_q;
  logic              w_held_q, w_held_d;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic [31:0]       regs_q [NUM_REGS];
  status_t           status_q, status_d;
  logic              perr_q;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  ar_idx;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic [STATUS_W-1:0] viol, sts_clr;
  logic              aw_drop, w_drop, ar_drop;
  logic              aw_change, w_change, ar_change;
  logic              unused_ok;

  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot};

  assign aw_hs  = s00_axi.awvalid & awready_q;
  assign w_hs   = s00_axi.wvalid & wready_q;
  assign ar_hs  = s00_axi.arvalid & arready_q;
  assign commit = aw_held_q & w_held_q;
  assign ar_idx = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  assign aw_held_d = aw_hs | (aw_held_q & ~commit);
  assign w_held_d  = w_hs | (w_held_q & ~commit);
  assign bvalid_d  = commit | (bvalid_q & ~s00_axi.bready);
  assign awready_d = ~aw_held_d & ~bvalid_d;
  assign wready_d  = ~w_held_d & ~bvalid_d;
  assign rvalid_d  = ar_hs | (rvalid_q & ~s00_axi.rready);
  assign arready_d = ~rvalid_d;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_data = regs_q[k];
        rd_resp = RESP_OKAY;
      end
    end
    if (ar_idx == STATUS_IDX) begin
      rd_data = {{(32-STATUS_W){1'b0}}, status_q};
      rd_resp = RESP_OKAY;
    end
  end

  // A violation seen in the clearing cycle survives the clear.
  always_comb begin
    viol              = '0;
    viol[STS_AW_DROP] = aw_drop;
    viol[STS_W_DROP]  = w_drop;
    viol[STS_AR_DROP] = ar_drop;
    viol[STS_PAYLOAD] = aw_change | w_change | ar_change;
    sts_clr           = '0;
    if (commit && aw_idx_q == STATUS_IDX && w_strb_q[0]) sts_clr = w_data_q[STATUS_W-1:0];
    status_d = status_t'((status_q & ~sts_clr) | viol);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      status_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      status_q  <= status_d;
      perr_q    <= |status_q;
      if (aw_hs) aw_idx_q <= s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data_q <= s00_axi.wdata;
        w_strb_q <= s00_axi.wstrb;
      end
      if (commit) bresp_q <= (aw_idx_q <= STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (aw_idx_q == IDX_W'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) regs_q[k][8*b +: 8] <= w_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  protocheck_valid_monitor #(.PAYLOAD_W(C_S_AXI_ADDR_WIDTH)) u_mon_aw (
    .clk_i    (s00_axi_aclk),
    .rst_ni   (s00_axi_aresetn),
    .valid_i  (s00_axi.awvalid),
    .ready_i  (awready_q),
    .payload_i(s00_axi.awaddr),
    .drop_o   (aw_drop),
    .change_o (aw_change)
  );

  protocheck_valid_monitor #(.PAYLOAD_W(32)) u_mon_w (
    .clk_i    (s00_axi_aclk),
    .rst_ni   (s00_axi_aresetn),
    .valid_i  (s00_axi.wvalid),
    .ready_i  (wready_q),
    .payload_i(s00_axi.wdata),
    .drop_o   (w_drop),
    .change_o (w_change)
  );

  protocheck_valid_monitor #(.PAYLOAD_W(C_S_AXI_ADDR_WIDTH)) u_mon_ar (
    .clk_i    (s00_axi_aclk),
    .rst_ni   (s00_axi_aresetn),
    .valid_i  (s00_axi.arvalid),
    .ready_i  (arready_q),
    .payload_i(s00_axi.araddr),
    .drop_o   (ar_drop),
    .change_o (ar_change)
  );

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) reg_out[32*k +: 32] = regs_q[k];
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;
  assign protocol_err    = perr_q;

endmodule

// File: tb/tb_protocheck_axil_slave.sv
// Directed bench for protocheck_axil_slave: register traffic, error decode,
// backpressure, protocol violation capture/clear and mid-transfer reset.
module tb_protocheck_axil_slave;
  import protocheck_axil_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] reg_out;
  logic         protocol_err;
  int           n_chk  = 0;
  int           n_fail = 0;

  protocheck_axil_slave_if #(.ADDR_W(5), .DATA_W(32)) bif ();

  protocheck_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_REGS          (4)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi        (bif),
    .reg_out        (reg_out),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int k);
    return reg_out[32*k +: 32];
  endfunction

  // Drives whatever AW/W valids are raised until each has handshaken.
  task automatic run_hs();
    int   cyc = 0;
    logic hs_aw, hs_w;
    while ((bif.awvalid || bif.wvalid) && cyc < 40) begin
      hs_aw = bif.awvalid && bif.awready;
      hs_w  = bif.wvalid && bif.wready;
      @(posedge clk); #1;
      cyc++;
      if (hs_aw) bif.awvalid = 1'b0;
      if (hs_w)  bif.wvalid  = 1'b0;
    end
    chk("aw_w_accepted", {bif.awvalid, bif.wvalid}, 2'b00);
    bif.awvalid = 1'b0;
    bif.wvalid  = 1'b0;
  endtask

  task automatic wait_bvalid();
    int cyc = 0;
    while (!bif.bvalid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bvalid_seen", bif.bvalid, 1'b1);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    wait_bvalid();
    resp = bif.bresp;
    bif.bready = 1'b1;
    @(posedge clk); #1;
    bif.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bif.awaddr  = addr;
    bif.wdata   = data;
    bif.wstrb   = strb;
    bif.awvalid = 1'b1;
    bif.wvalid  = 1'b1;
    run_hs();
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    bif.araddr  = addr;
    bif.arvalid = 1'b1;
    while (!bif.arready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    bif.arvalid = 1'b0;
    chk("rvalid_seen", bif.rvalid, 1'b1);
    data = bif.rdata;
    resp = bif.rresp;
    bif.rready = 1'b1;
    @(posedge clk); #1;
    bif.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    rst_n       = 1'b0;
    bif.awaddr  = '0;  bif.awprot = '0;  bif.awvalid = 1'b0;
    bif.wdata   = '0;  bif.wstrb  = '0;  bif.wvalid  = 1'b0;
    bif.bready  = 1'b0;
    bif.araddr  = '0;  bif.arprot = '0;  bif.arvalid = 1'b0;
    bif.rready  = 1'b0;

    #12;
    chk("rst_awready", bif.awready, 1'b0);
    chk("rst_wready", bif.wready, 1'b0);
    chk("rst_arready", bif.arready, 1'b0);
    chk("rst_bvalid", bif.bvalid, 1'b0);
    chk("rst_rvalid", bif.rvalid, 1'b0);
    chk("rst_rdata", bif.rdata, 32'h0);
    chk("rst_reg_out", reg_out[63:0] | reg_out[127:64], 64'h0);
    chk("rst_perr", protocol_err, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_rst", bif.awready, 1'b1);

    // Basic write/read-back of every data register
    for (int k = 0; k < 4; k++) begin
      axi_write(5'(4*k), 32'(k+1), 4'hF, rsp);
      chk("t1_bresp", rsp, RESP_OKAY);
    end
    for (int k = 0; k < 4; k++) begin
      axi_read(5'(4*k), rd, rsp);
      chk("t1_rdata", rd, 32'(k+1));
      chk("t1_rresp", rsp, RESP_OKAY);
    end

    // AW two cycles ahead of W, single-byte strobe
    bif.awaddr  = 5'h00;
    bif.awvalid = 1'b1;
    chk("t2_awready", bif.awready, 1'b1);
    @(posedge clk); #1;
    bif.awvalid = 1'b0;
    @(posedge clk); #1;
    bif.wdata  = 32'hAABBCCDD;
    bif.wstrb  = 4'b0010;
    bif.wvalid = 1'b1;
    chk("t2_wready", bif.wready, 1'b1);
    @(posedge clk); #1;
    bif.wvalid = 1'b0;
    chk("t2_bvalid_early", bif.bvalid, 1'b0);
    @(posedge clk); #1;
    chk("t2_bvalid", bif.bvalid, 1'b1);
    chk("t2_reg0", rg(0), 32'h0000CC01);
    wait_b(rsp);
    chk("t2_bresp", rsp, RESP_OKAY);

    // Out-of-range addresses
    axi_write(5'h14, 32'hDEADBEEF, 4'hF, rsp);
    chk("t3_bresp", rsp, RESP_SLVERR);
    chk("t3_reg0", rg(0), 32'h0000CC01);
    chk("t3_reg1", rg(1), 32'h2);
    chk("t3_reg2", rg(2), 32'h3);
    chk("t3_reg3", rg(3), 32'h4);
    axi_read(5'h18, rd, rsp);
    chk("t3_rresp", rsp, RESP_SLVERR);
    chk("t3_rdata", rd, 32'h0);
    axi_read(5'h10, rd, rsp);
    chk("t3_status_clean", rd, 32'h0);
    chk("t3_status_rresp", rsp, RESP_OKAY);

    // B backpressure blocks a second write
    bif.awaddr = 5'h04; bif.wdata = 32'h55; bif.wstrb = 4'hF;
    bif.awvalid = 1'b1; bif.wvalid = 1'b1;
    run_hs();
    wait_bvalid();
    bif.awaddr  = 5'h08;
    bif.wdata   = 32'h77;
    bif.awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4_bvalid_hold", bif.bvalid, 1'b1);
      chk("t4_awready", bif.awready, 1'b0);
      chk("t4_wready", bif.wready, 1'b0);
    end
    chk("t4_bresp", bif.bresp, RESP_OKAY);
    chk("t4_reg1", rg(1), 32'h55);
    chk("t4_reg2_held", rg(2), 32'h3);
    bif.bready = 1'b1;
    @(posedge clk); #1;
    bif.bready = 1'b0;
    bif.wvalid = 1'b1;
    run_hs();
    wait_b(rsp);
    chk("t4_bresp2", rsp, RESP_OKAY);
    chk("t4_reg2", rg(2), 32'h77);

    // AWVALID pulse without handshake sets STATUS bit0
    bif.awaddr = 5'h1C; bif.wdata = 32'h0;
    bif.awvalid = 1'b1; bif.wvalid = 1'b1;
    run_hs();
    wait_bvalid();
    chk("t5_awready_low", bif.awready, 1'b0);
    bif.awaddr  = 5'h00;
    bif.awvalid = 1'b1;
    @(posedge clk); #1;
    bif.awvalid = 1'b0;
    @(posedge clk); #1;
    chk("t5_perr_lag", protocol_err, 1'b0);
    @(posedge clk); #1;
    chk("t5_perr_set", protocol_err, 1'b1);
    axi_read(5'h10, rd, rsp);
    chk("t5_status", rd, 32'h1);
    chk("t5_status_rresp", rsp, RESP_OKAY);
    wait_b(rsp);
    chk("t5_bresp_1c", rsp, RESP_SLVERR);
    axi_write(5'h10, 32'h1, 4'hF, rsp);
    chk("t5_clr_bresp", rsp, RESP_OKAY);
    chk("t5_perr_clr", protocol_err, 1'b0);
    axi_read(5'h10, rd, rsp);
    chk("t5_status_clr", rd, 32'h0);

    // AWADDR changes while stalled sets STATUS bit3
    bif.awaddr = 5'h1C; bif.wdata = 32'h0;
    bif.awvalid = 1'b1; bif.wvalid = 1'b1;
    run_hs();
    wait_bvalid();
    bif.awaddr  = 5'h00;
    bif.awvalid = 1'b1;
    @(posedge clk); #1;
    bif.awaddr = 5'h04;
    @(posedge clk); #1;
    bif.bready = 1'b1;
    @(posedge clk); #1;
    bif.bready = 1'b0;
    bif.wdata  = 32'h99;
    bif.wstrb  = 4'hF;
    bif.wvalid = 1'b1;
    run_hs();
    wait_b(rsp);
    chk("t6_bresp", rsp, RESP_OKAY);
    chk("t6_reg1", rg(1), 32'h99);
    chk("t6_reg0", rg(0), 32'h0000CC01);
    axi_read(5'h10, rd, rsp);
    chk("t6_status", rd, 32'h8);
    chk("t6_perr", protocol_err, 1'b1);
    axi_write(5'h10, 32'h8, 4'hF, rsp);
    axi_read(5'h10, rd, rsp);
    chk("t6_status_clr", rd, 32'h0);

    // Reset while a write response is pending
    bif.awaddr = 5'h0C; bif.wdata = 32'h1234; bif.wstrb = 4'hF;
    bif.awvalid = 1'b1; bif.wvalid = 1'b1;
    run_hs();
    wait_bvalid();
    chk("t7_reg3", rg(3), 32'h1234);
    rst_n = 1'b0;
    #1;
    chk("t7_bvalid", bif.bvalid, 1'b0);
    chk("t7_awready", bif.awready, 1'b0);
    chk("t7_wready", bif.wready, 1'b0);
    chk("t7_arready", bif.arready, 1'b0);
    chk("t7_reg_out", reg_out[63:0] | reg_out[127:64], 64'h0);
    chk("t7_perr", protocol_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t7_reg_out_rel", reg_out[63:0] | reg_out[127:64], 64'h0);
    chk("t7_awready_rel", bif.awready, 1'b1);
    chk("t7_bvalid_rel", bif.bvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
